// File: rtl/bitstream_ena_ctrl_if.sv
// Handshake bundle between the decoder top level and the enable controller.
// The master drives enables/requests in; the slave (controller) returns gated enables and status.
interface bitstream_ena_ctrl_if #(
  parameter int NUM_STAGES = 4,
  parameter int NUM_TAIL   = 5
);
  logic                  ena;
  logic [NUM_STAGES-1:0] valid;
  logic [NUM_STAGES-1:0] sel;
  logic [NUM_STAGES-1:0] busy;
  logic                  pause_req;
  logic                  stall_clr;
  logic [NUM_STAGES-1:0] stage_ena;
  logic [NUM_TAIL-1:0]   tail_ena;
  logic                  pause_ack;
  logic [1:0]            fsm_state;
  logic                  stall_timeout;
  logic [31:0]           stall_total;

  modport master (
    output ena, valid, sel, busy, pause_req, stall_clr,
    input  stage_ena, tail_ena, pause_ack, fsm_state, stall_timeout, stall_total
  );

  modport slave (
    input  ena, valid, sel, busy, pause_req, stall_clr,
    output stage_ena, tail_ena, pause_ack, fsm_state, stall_timeout, stall_total
  );
endinterface

// File: rtl/bitstream_ena_ctrl.sv
// Cascaded stage enables, free-running tail enables, pause/drain/resume FSM and stall watchdog.
// Optional BITSTREAM_ENA_STALL_CNT_EN adds a 32-bit cumulative stall-cycle counter.
module bitstream_ena_ctrl #(
  parameter int NUM_STAGES  = 4,
  parameter int NUM_TAIL    = 5,
  parameter int RESUME_CYC  = 2,
  parameter int CNT_W       = 16,
  parameter int STALL_LIMIT = 1000
) (
  input logic                 clk,
  input logic                 rst,
  bitstream_ena_ctrl_if.slave bus
);

  localparam int RC_W = (RESUME_CYC > 1) ? $clog2(RESUME_CYC) : 1;
  localparam logic [RC_W-1:0]  RC_LOAD  = RC_W'(RESUME_CYC - 1);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STALL_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STALL_LIMIT - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_PAUSED = 2'd2,
    ST_RESUME = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [RC_W-1:0]       r_resume_cnt, w_resume_cnt_nxt;
  logic                  r_pause_ack, w_pause_ack_nxt;
  logic [CNT_W-1:0]      r_stall_cnt;
  logic                  r_stall_timeout;
  logic [NUM_STAGES-1:0] w_chain;
  logic [NUM_STAGES-1:0] w_sel_eff;
  logic                  w_head_gate;
  logic                  w_down_gate;
  logic                  w_stall_inc;

  // Head stage is never select-gated, so force its select bit on.
  assign w_sel_eff   = bus.sel | {{(NUM_STAGES-1){1'b0}}, 1'b1};
  assign w_head_gate = ~rst & bus.ena & (r_state == ST_RUN);
  assign w_down_gate = ~rst & bus.ena & ((r_state == ST_RUN) | (r_state == ST_DRAIN));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      assign w_chain[gi] = &bus.valid[gi:0];
      if (gi == 0) begin : g_head
        assign bus.stage_ena[gi] = w_head_gate & w_chain[gi] & w_sel_eff[gi];
      end else begin : g_down
        assign bus.stage_ena[gi] = w_down_gate & w_chain[gi] & w_sel_eff[gi];
      end
    end
  endgenerate

  assign bus.tail_ena  = {NUM_TAIL{~rst & bus.ena & (r_state != ST_PAUSED)}};
  assign bus.fsm_state = r_state;
  assign bus.pause_ack = r_pause_ack;

  always_comb begin
    w_state_nxt      = r_state;
    w_resume_cnt_nxt = r_resume_cnt;
    case (r_state)
      ST_RUN: begin
        if (bus.pause_req) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!bus.pause_req)    w_state_nxt = ST_RUN;
        else if (bus.busy == '0) w_state_nxt = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (!bus.pause_req) begin
          w_state_nxt      = ST_RESUME;
          w_resume_cnt_nxt = RC_LOAD;
        end
      end
      ST_RESUME: begin
        if (bus.pause_req)            w_state_nxt = ST_DRAIN;
        else if (r_resume_cnt == '0)  w_state_nxt = ST_RUN;
        else                          w_resume_cnt_nxt = r_resume_cnt - 1'b1;
      end
      default: w_state_nxt = ST_RUN;
    endcase
    // Ack rises the cycle after PAUSED is entered and drops on the exit edge.
    w_pause_ack_nxt = (r_state == ST_PAUSED) && (w_state_nxt == ST_PAUSED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_resume_cnt <= '0;
      r_pause_ack  <= 1'b0;
    end else if (bus.ena) begin
      r_state      <= w_state_nxt;
      r_resume_cnt <= w_resume_cnt_nxt;
      r_pause_ack  <= w_pause_ack_nxt;
    end
  end

  assign w_stall_inc = bus.ena & (r_state == ST_RUN) & ~w_chain[NUM_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt     <= '0;
      r_stall_timeout <= 1'b0;
    end else begin
      if (bus.ena) begin
        if (!w_stall_inc)          r_stall_cnt <= '0;
        else if (r_stall_cnt != LIMIT) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      // Clear beats a coincident set; a saturated counter re-arms the flag next stall cycle.
      if (bus.stall_clr)                               r_stall_timeout <= 1'b0;
      else if (w_stall_inc && (r_stall_cnt >= LIMIT_M1)) r_stall_timeout <= 1'b1;
    end
  end

  assign bus.stall_timeout = r_stall_timeout;

`ifdef BITSTREAM_ENA_STALL_CNT_EN
  logic [31:0] r_stall_total;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_stall_total <= '0;
    else if (w_stall_inc) r_stall_total <= r_stall_total + 32'd1;
  end

  assign bus.stall_total = r_stall_total;
`else
  assign bus.stall_total = '0;
`endif

endmodule

// File: tb/tb_bitstream_ena_ctrl.sv
// Directed plus randomized bench for bitstream_ena_ctrl against a cycle-level behavioural model.
module tb_bitstream_ena_ctrl;

  localparam int NS    = 4;
  localparam int NT    = 5;
  localparam int RCYC  = 2;
  localparam int LIMIT = 1000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  bitstream_ena_ctrl_if #(.NUM_STAGES(NS), .NUM_TAIL(NT)) bus ();

  bitstream_ena_ctrl #(
    .NUM_STAGES(NS), .NUM_TAIL(NT), .RESUME_CYC(RCYC), .CNT_W(16), .STALL_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 running, 1 draining, 2 paused, 3 resuming.
  int          m_mode;
  int          m_resume_left;
  bit          m_ack;
  int          m_stall_run;
  bit          m_flag;
  logic [31:0] m_total;

  task automatic m_reset();
    m_mode = 0; m_resume_left = 0; m_ack = 0; m_stall_run = 0; m_flag = 0; m_total = '0;
  endtask

  function automatic logic [NS-1:0] exp_stage();
    logic [NS-1:0] e;
    bit all_up;
    e = '0;
    all_up = 1;
    for (int i = 0; i < NS; i++) begin
      all_up = all_up && bus.valid[i];
      if (rst || !bus.ena || !all_up) e[i] = 1'b0;
      else if (i == 0)                e[i] = (m_mode == 0);
      else                            e[i] = (m_mode <= 1) && bus.sel[i];
    end
    return e;
  endfunction

  function automatic logic [NT-1:0] exp_tail();
    return (!rst && bus.ena && m_mode != 2) ? {NT{1'b1}} : '0;
  endfunction

  function automatic logic [31:0] exp_total();
`ifdef BITSTREAM_ENA_STALL_CNT_EN
    return m_total;
`else
    return 32'd0;
`endif
  endfunction

  // One rising edge of the model, using the inputs present at that edge.
  task automatic m_edge();
    int  old_mode;
    bit  stalled;
    if (!bus.ena) begin
      if (bus.stall_clr) m_flag = 0;
      return;
    end
    old_mode = m_mode;
    stalled  = (m_mode == 0) && (bus.valid != {NS{1'b1}});
    if (stalled) begin
      m_total = m_total + 1;
      if (m_stall_run < LIMIT) m_stall_run++;
    end else begin
      m_stall_run = 0;
    end
    if (bus.stall_clr)                        m_flag = 0;
    else if (stalled && m_stall_run == LIMIT) m_flag = 1;
    case (old_mode)
      0: if (bus.pause_req) m_mode = 1;
      1: if (!bus.pause_req) m_mode = 0; else if (bus.busy == '0) m_mode = 2;
      2: if (!bus.pause_req) begin m_mode = 3; m_resume_left = RCYC - 1; end
      default: begin
        if (bus.pause_req)           m_mode = 1;
        else if (m_resume_left == 0) m_mode = 0;
        else                         m_resume_left--;
      end
    endcase
    m_ack = (old_mode == 2) && (m_mode == 2);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("stage_ena", 32'(bus.stage_ena), 32'(exp_stage()));
    chk("tail_ena", 32'(bus.tail_ena), 32'(exp_tail()));
    chk("fsm_state", 32'(bus.fsm_state), 32'(m_mode));
    chk("pause_ack", 32'(bus.pause_ack), 32'(m_ack));
    chk("stall_timeout", 32'(bus.stall_timeout), 32'(m_flag));
    chk("stall_total", bus.stall_total, exp_total());
  endtask

  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
    check_all();
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1;
    bus.ena = 0; bus.valid = '0; bus.sel = '0; bus.busy = '0;
    bus.pause_req = 0; bus.stall_clr = 0;
    m_reset();
    @(posedge clk); @(posedge clk); #1;
    check_all();
    chk("rst_stage_zero", 32'(bus.stage_ena), 32'd0);

    // 1: full chain runs every stage
    rst = 1'b0;
    bus.ena = 1; bus.valid = 4'b1111; bus.sel = 4'b1110;
    settle();
    chk("s1_stage", 32'(bus.stage_ena), 32'h0000000F);
    chk("s1_tail", 32'(bus.tail_ena), 32'h0000001F);
    step();

    // 2: broken chain, watchdog, clear/re-set behaviour
    bus.valid = 4'b1011;
    settle();
    chk("s2_stage", 32'(bus.stage_ena), 32'h00000003);
    for (int i = 0; i < LIMIT - 1; i++) step();
    chk("s2_flag_before", 32'(bus.stall_timeout), 32'd0);
    step();
    chk("s2_flag_set", 32'(bus.stall_timeout), 32'd1);
    bus.stall_clr = 1; step();
    chk("s2_flag_clr", 32'(bus.stall_timeout), 32'd0);
    bus.stall_clr = 0; step();
    chk("s2_flag_reset", 32'(bus.stall_timeout), 32'd1);
    bus.valid = 4'hF; step();
    bus.stall_clr = 1; step();
    bus.stall_clr = 0;
    for (int i = 0; i < 3; i++) step();
    chk("s2_flag_stays", 32'(bus.stall_timeout), 32'd0);

    // 3: pause with busy downstream
    bus.pause_req = 1; bus.busy = 4'b0110;
    settle();
    step();
    chk("s3_drain_state", 32'(bus.fsm_state), 32'd1);
    chk("s3_drain_stage", 32'(bus.stage_ena), 32'h0000000E);
    step(); step();
    bus.busy = '0;
    step();
    chk("s3_paused", 32'(bus.fsm_state), 32'd2);
    chk("s3_ack_late", 32'(bus.pause_ack), 32'd0);
    chk("s3_tail_off", 32'(bus.tail_ena), 32'd0);
    step();
    chk("s3_ack", 32'(bus.pause_ack), 32'd1);

    // 4: resume window
    bus.pause_req = 0;
    step();
    chk("s4_resume", 32'(bus.fsm_state), 32'd3);
    chk("s4_stage_off", 32'(bus.stage_ena), 32'd0);
    chk("s4_tail_on", 32'(bus.tail_ena), 32'h0000001F);
    step();
    chk("s4_resume2", 32'(bus.fsm_state), 32'd3);
    step();
    chk("s4_run", 32'(bus.fsm_state), 32'd0);

    // 5: drain abort, then ena hold-off during resume
    bus.pause_req = 1; bus.busy = 4'b0001;
    step();
    bus.pause_req = 0;
    step();
    chk("s5_abort", 32'(bus.fsm_state), 32'd0);
    chk("s5_no_ack", 32'(bus.pause_ack), 32'd0);
    bus.busy = '0; bus.pause_req = 1;
    step(); step(); step();
    bus.pause_req = 0;
    step();
    bus.ena = 0;
    settle();
    for (int i = 0; i < 3; i++) step();
    chk("s5_hold_state", 32'(bus.fsm_state), 32'd3);
    chk("s5_hold_tail", 32'(bus.tail_ena), 32'd0);
    bus.ena = 1;
    step();
    chk("s5_resume_cont", 32'(bus.fsm_state), 32'd3);
    step();
    chk("s5_run", 32'(bus.fsm_state), 32'd0);

    // 6: asynchronous reset while paused, then stall total
    bus.pause_req = 1;
    step(); step(); step();
    chk("s6_pre_ack", 32'(bus.pause_ack), 32'd1);
    #2 rst = 1'b1;
    #1 m_reset();
    check_all();
    chk("s6_rst_state", 32'(bus.fsm_state), 32'd0);
    chk("s6_rst_ack", 32'(bus.pause_ack), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus.pause_req = 0; bus.valid = 4'b0111;
    settle();
    for (int i = 0; i < 10; i++) step();
`ifdef BITSTREAM_ENA_STALL_CNT_EN
    chk("s6_total", bus.stall_total, 32'd10);
`else
    chk("s6_total", bus.stall_total, 32'd0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      bus.ena   = ($urandom_range(0, 9) != 0);
      bus.valid = '0;
      for (int b = 0; b < NS; b++) bus.valid[b] = ($urandom_range(0, 7) != 0);
      bus.sel   = NS'($urandom);
      bus.busy  = ($urandom_range(0, 2) == 0) ? NS'($urandom) : '0;
      if ($urandom_range(0, 7) == 0) bus.pause_req = ~bus.pause_req;
      bus.stall_clr = ($urandom_range(0, 15) == 0);
      settle();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
